// File: rtl/simon_round_engine.sv
// Iterative Simon 64/128 and 128/128 encryptor.
// One round per clock, round keys read by index from the key expander.
module simon_round_engine #(
  parameter int SIMON_MAX_ROUNDS     = 68,
  parameter int SIMON_MAX_WORD_WIDTH = 64,
  parameter int SIMON_BLOCK_WIDTH    = 128
) (
  input  logic                               ck,
  input  logic                               nrst,
  input  logic                               mode,
  input  logic                               kexp_valid,
  output logic [$clog2(SIMON_MAX_ROUNDS)-1:0] rk_idx,
  input  logic [SIMON_MAX_WORD_WIDTH-1:0]    rk,
  input  logic [SIMON_BLOCK_WIDTH-1:0]       pt,
  input  logic                               pt_valid,
  output logic                               pt_ready,
  output logic [SIMON_BLOCK_WIDTH-1:0]       ct,
  output logic                               ct_valid,
  input  logic                               ct_ready
);

  localparam int WW  = SIMON_MAX_WORD_WIDTH;
  localparam int HW  = WW / 2;
  localparam int BW  = SIMON_BLOCK_WIDTH;
  localparam int IW  = $clog2(SIMON_MAX_ROUNDS);
  localparam int R64 = 44;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_mode;
  logic          w_mode_nx;
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] w_cnt_nx;
  logic [WW-1:0] r_x;
  logic [WW-1:0] r_y;
  logic [WW-1:0] w_x_nx;
  logic [WW-1:0] w_y_nx;
  logic [WW-1:0] w_x_rnd;
  logic [IW-1:0] w_last;
  logic          w_accept;

  function automatic logic [WW-1:0] f_full(
    input logic [WW-1:0] a
  );
    return ({a[WW-2:0], a[WW-1]}
          & {a[WW-9:0], a[WW-1:WW-8]})
          ^ {a[WW-3:0], a[WW-1:WW-2]};
  endfunction

  function automatic logic [HW-1:0] f_half(
    input logic [HW-1:0] a
  );
    return ({a[HW-2:0], a[HW-1]}
          & {a[HW-9:0], a[HW-1:HW-8]})
          ^ {a[HW-3:0], a[HW-1:HW-2]};
  endfunction

  assign w_accept = (r_state == S_IDLE)
                  & kexp_valid & pt_valid;
  assign w_last   = r_mode
                  ? IW'(SIMON_MAX_ROUNDS - 1)
                  : IW'(R64 - 1);

  // 64/128 keeps the upper half of each word at zero
  assign w_x_rnd = r_mode
    ? (r_y ^ f_full(r_x) ^ rk)
    : {{HW{1'b0}},
       r_y[HW-1:0] ^ f_half(r_x[HW-1:0]) ^ rk[HW-1:0]};

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_cnt_nx   = r_cnt;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = S_RUN;
          w_mode_nx  = mode;
          w_cnt_nx   = '0;
          if (mode) begin
            w_x_nx = pt[BW-1:WW];
            w_y_nx = pt[WW-1:0];
          end else begin
            w_x_nx = {{HW{1'b0}}, pt[WW-1:HW]};
            w_y_nx = {{HW{1'b0}}, pt[HW-1:0]};
          end
        end
      end
      S_RUN: begin
        if (!kexp_valid) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_x_nx = w_x_rnd;
          w_y_nx = r_x;
          if (r_cnt == w_last) begin
            w_state_nx = S_DONE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + IW'(1);
          end
        end
      end
      S_DONE: begin
        if (ct_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_cnt   <= w_cnt_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
    end
  end

  assign rk_idx   = r_cnt;
  assign pt_ready = (r_state == S_IDLE) & kexp_valid;
  assign ct_valid = (r_state == S_DONE);
  assign ct = r_mode
    ? {r_x, r_y}
    : {{(BW-WW){1'b0}}, r_x[HW-1:0], r_y[HW-1:0]};

endmodule

// File: tb/tb_simon_round_engine.sv
// Directed bench for simon_round_engine against published Simon vectors.
// Round keys come from a behavioural key expander model.
module tb_simon_round_engine;

  logic         ck = 1'b0;
  logic         nrst;
  logic         mode;
  logic         kexp_valid;
  logic [6:0]   rk_idx;
  logic [63:0]  rk;
  logic [127:0] pt;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] ct;
  logic         ct_valid;
  logic         ct_ready;

  int vecs = 0;
  int errs = 0;

  logic         kmode;
  logic [31:0]  k32 [0:67];
  logic [63:0]  k64 [0:67];
  logic [61:0]  z2;
  logic [61:0]  z3;

  localparam logic [127:0] PT64 =
    128'hdeadbeef_cafef00d_656b696c_20646e75;
  localparam logic [127:0] CT64 =
    128'h0_44c8fc20_b9dfa07a;
  localparam logic [127:0] PT128 =
    128'h6373656420737265_6c6c657661727420;
  localparam logic [127:0] CT128 =
    128'h49681b1e1e54fe3f_65aa832af84e0bbc;

  simon_round_engine dut (
    .ck         (ck),
    .nrst       (nrst),
    .mode       (mode),
    .kexp_valid (kexp_valid),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .pt         (pt),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .ct         (ct),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready)
  );

  always #5 ck = ~ck;

  assign rk = kmode ? k64[rk_idx]
                    : {32'h0, k32[rk_idx]};

  function automatic logic [31:0] ror3_32(input logic [31:0] a);
    return {a[2:0], a[31:3]};
  endfunction
  function automatic logic [31:0] ror1_32(input logic [31:0] a);
    return {a[0], a[31:1]};
  endfunction
  function automatic logic [63:0] ror3_64(input logic [63:0] a);
    return {a[2:0], a[63:3]};
  endfunction
  function automatic logic [63:0] ror1_64(input logic [63:0] a);
    return {a[0], a[63:1]};
  endfunction

  task automatic expand_keys();
    logic [31:0] t32;
    logic [63:0] t64;
    z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    for (int i = 0; i < 68; i++) begin
      k32[i] = '0;
      k64[i] = '0;
    end
    k32[0] = 32'h03020100;
    k32[1] = 32'h0b0a0908;
    k32[2] = 32'h13121110;
    k32[3] = 32'h1b1a1918;
    for (int i = 4; i < 44; i++) begin
      t32 = ror3_32(k32[i-1]) ^ k32[i-3];
      t32 = t32 ^ ror1_32(t32);
      k32[i] = ~k32[i-4] ^ t32
             ^ {31'b0, z3[61 - ((i - 4) % 62)]}
             ^ 32'd3;
    end
    k64[0] = 64'h0706050403020100;
    k64[1] = 64'h0f0e0d0c0b0a0908;
    for (int i = 2; i < 68; i++) begin
      t64 = ror3_64(k64[i-1]);
      t64 = t64 ^ ror1_64(t64);
      k64[i] = ~k64[i-2] ^ t64
             ^ {63'b0, z2[61 - ((i - 2) % 62)]}
             ^ 64'd3;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #2;
  endtask

  // accept one block from IDLE and wait for ct_valid
  task automatic blk(input logic m,
                     input logic [127:0] p,
                     input logic [127:0] e,
                     input int r,
                     input string tag);
    int  n;
    bit  sweep_ok;
    kmode      = m;
    mode       = m;
    pt         = p;
    pt_valid   = 1'b1;
    kexp_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, 128'(pt_ready), 128'd1);
    tick();
    pt_valid = 1'b0;
    mode     = ~m;
    pt       = {$urandom, $urandom, $urandom, $urandom};
    n        = 0;
    sweep_ok = 1'b1;
    while (!ct_valid && n < 200) begin
      if (rk_idx !== 7'(n)) sweep_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(r));
    chk({tag, "_ct"}, ct, e);
    chk({tag, "_sweep"}, 128'(sweep_ok), 128'd1);
    chk({tag, "_idx_done"}, 128'(rk_idx), 128'd0);
  endtask

  initial begin
    bit seen;
    expand_keys();
    nrst       = 1'b0;
    mode       = 1'b0;
    kmode      = 1'b0;
    kexp_valid = 1'b0;
    pt         = '0;
    pt_valid   = 1'b0;
    ct_ready   = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    chk("rst_ct_valid", 128'(ct_valid), 128'd0);
    chk("rst_ct", ct, 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    chk("rst_pt_ready", 128'(pt_ready), 128'd0);

    // plaintext offered without expanded keys must be ignored
    pt_valid = 1'b1;
    pt       = PT64;
    tick();
    tick();
    tick();
    chk("nokey_pt_ready", 128'(pt_ready), 128'd0);
    chk("nokey_rk_idx", 128'(rk_idx), 128'd0);
    chk("nokey_ct_valid", 128'(ct_valid), 128'd0);

    blk(1'b0, PT64, CT64, 44, "b64");

    // backpressure with ct_ready low
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_ct_valid", 128'(ct_valid), 128'd1);
      chk("bp_ct", ct, CT64);
      chk("bp_pt_ready", 128'(pt_ready), 128'd0);
    end
    ct_ready = 1'b1;
    tick();
    ct_ready = 1'b0;
    chk("bp_release_valid", 128'(ct_valid), 128'd0);
    chk("bp_release_ready", 128'(pt_ready), 128'd1);

    ct_ready = 1'b1;
    blk(1'b1, PT128, CT128, 68, "b128");
    tick();
    chk("b128_pulse", 128'(ct_valid), 128'd0);

    // reset in the middle of a 128/128 block
    kmode    = 1'b1;
    mode     = 1'b1;
    pt       = PT128;
    pt_valid = 1'b1;
    tick();
    pt_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_rk_idx", 128'(rk_idx), 128'd20);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("mrst_rk_idx", 128'(rk_idx), 128'd0);
    chk("mrst_ct_valid", 128'(ct_valid), 128'd0);
    chk("mrst_pt_ready", 128'(pt_ready), 128'd1);
    chk("mrst_ct", ct, 128'd0);
    blk(1'b0, PT64, CT64, 44, "post_rst");
    tick();

    // expander drops valid at round 10
    kmode    = 1'b0;
    mode     = 1'b0;
    pt       = PT64;
    pt_valid = 1'b1;
    tick();
    pt_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_mid_idx", 128'(rk_idx), 128'd10);
    kexp_valid = 1'b0;
    tick();
    chk("abort_rk_idx", 128'(rk_idx), 128'd0);
    chk("abort_pt_ready", 128'(pt_ready), 128'd0);
    kexp_valid = 1'b1;
    #1;
    chk("abort_idle", 128'(pt_ready), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ct_valid) seen = 1'b1;
    end
    chk("abort_no_ct", 128'(seen), 128'd0);

    // back-to-back blocks with ct_ready held high
    blk(1'b0, PT64, CT64, 44, "btb64");
    tick();
    blk(1'b1, PT128, CT128, 68, "btb128");
    tick();
    chk("btb_end_idle", 128'(pt_ready), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
